// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: in-order issue controller with a register scoreboard, hazard stall and redirect flush
//   clk, rst_n                      clock (rising edge) and async active-low reset
//   dec_valid/rs1/rs2/rd/use_*/wr_rd decoded instruction fields from decode
//   exec_busy, exec_redirect        execute back-pressure and taken branch/jump
//   wb_valid, wb_rd, wb_retire      writeback and retirement from the back end
//   ftch_stall, dec_issue, dec_flush combinational pipeline controls
//   ctrl_state, ctrl_pending, ctrl_inflight  FSM state, scoreboard and in-flight count
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES    = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WB_BYPASS       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic        dec_wr_rd,
  input  logic        exec_busy,
  input  logic        exec_redirect,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_retire,
  output logic        ftch_stall,
  output logic        dec_issue,
  output logic        dec_flush,
  output logic [1:0]  ctrl_state,
  output logic [31:0] ctrl_pending,
  output logic [3:0]  ctrl_inflight
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  state_t        state;
  logic [CW-1:0] fcnt;
  logic [31:0]   pend, pend_nxt;
  logic [3:0]    inflight;
  logic          h1, h2, hd, full, stall, hold;
  // A same-cycle writeback to the register being checked removes the hazard when bypass is enabled
  assign h1 = dec_use_rs1 && dec_rs1 != '0 && pend[dec_rs1] && !(WB_BYPASS != 0 && wb_valid && wb_rd == dec_rs1);
  assign h2 = dec_use_rs2 && dec_rs2 != '0 && pend[dec_rs2] && !(WB_BYPASS != 0 && wb_valid && wb_rd == dec_rs2);
  assign hd = dec_wr_rd && dec_rd != '0 && pend[dec_rd] && !(WB_BYPASS != 0 && wb_valid && wb_rd == dec_rd);
  // A retirement in the same cycle frees the slot the new instruction would take
  assign full  = inflight == 4'(MAX_OUTSTANDING) && !wb_retire;
  assign stall = dec_valid && (h1 || h2 || hd || exec_busy || full);
  assign hold  = state == FLUSH || exec_redirect;
  assign dec_flush  = rst_n && hold;
  assign ftch_stall = rst_n && !hold && stall;
  assign dec_issue  = rst_n && !hold && dec_valid && !stall;
  assign ctrl_state    = state;
  assign ctrl_pending  = pend;
  assign ctrl_inflight = inflight;
  // Clear before set so an issue to the register being written back leaves it pending
  always_comb begin
    pend_nxt = pend;
    if (wb_valid) pend_nxt[wb_rd] = 1'b0;
    if (dec_issue && dec_wr_rd && dec_rd != '0) pend_nxt[dec_rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fcnt     <= '0;
      pend     <= '0;
      inflight <= '0;
    end else begin
      pend     <= pend_nxt;
      inflight <= inflight + 4'(dec_issue) - 4'(wb_retire && inflight != '0);
      if (exec_redirect) begin
        state <= FLUSH;
        fcnt  <= CW'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH) begin
        if (fcnt == '0) state <= RUN;
        else fcnt <= fcnt - CW'(1);
      end else begin
        state <= stall ? STALL : RUN;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
  localparam int FC = 2, MO = 4, BYP = 1;
  logic clk = 0, rst_n = 0;
  logic dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_rd, exec_busy, exec_redirect, wb_valid, wb_retire;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic ftch_stall, dec_issue, dec_flush;
  logic [1:0] ctrl_state;
  logic [31:0] ctrl_pending;
  logic [3:0] ctrl_inflight;
  pipeline_ctrl #(.FLUSH_CYCLES(FC), .MAX_OUTSTANDING(MO), .WB_BYPASS(BYP)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .exec_busy(exec_busy), .exec_redirect(exec_redirect), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_retire(wb_retire), .ftch_stall(ftch_stall), .dec_issue(dec_issue), .dec_flush(dec_flush),
    .ctrl_state(ctrl_state), .ctrl_pending(ctrl_pending), .ctrl_inflight(ctrl_inflight));
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  bit m_pend[32];
  int m_infl, m_left;
  bit m_stalled, e_stl, e_stall, e_issue, e_flush;
  int e_state;
  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_infl = 0; m_left = 0; m_stalled = 0;
  endtask
  function automatic bit reg_hz(bit u, logic [4:0] r);
    return u && r != 0 && m_pend[r] && !(BYP != 0 && wb_valid && wb_rd == r);
  endfunction
  function automatic logic [31:0] pend_word();
    logic [31:0] w;
    foreach (m_pend[i]) w[i] = m_pend[i];
    return w;
  endfunction
  task automatic model_eval();
    bit hz;
    hz = reg_hz(dec_use_rs1, dec_rs1) || reg_hz(dec_use_rs2, dec_rs2) || reg_hz(dec_wr_rd, dec_rd);
    e_stl   = dec_valid && (hz || exec_busy || (m_infl == MO && !wb_retire));
    e_flush = rst_n && (m_left > 0 || exec_redirect);
    e_stall = rst_n && !e_flush && e_stl;
    e_issue = rst_n && !e_flush && dec_valid && !e_stl;
    e_state = m_left > 0 ? 2 : m_stalled ? 1 : 0;
  endtask
  function automatic logic [41:0] expv();
    return {e_stall, e_issue, e_flush, 2'(e_state), pend_word(), 4'(m_infl)};
  endfunction
  function automatic logic [41:0] gotv();
    return {ftch_stall, dec_issue, dec_flush, ctrl_state, ctrl_pending, ctrl_inflight};
  endfunction
  task automatic set_in(bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, bit u1, bit u2, bit w,
                        bit busy, bit redir, bit wbv, logic [4:0] wbr, bit ret);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_use_rs1 = u1; dec_use_rs2 = u2;
    dec_wr_rd = w; exec_busy = busy; exec_redirect = redir; wb_valid = wbv; wb_rd = wbr; wb_retire = ret;
  endtask
  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask
  task automatic tick();
    int old;
    @(posedge clk);
    if (rst_n) begin
      if (wb_valid) m_pend[wb_rd] = 0;
      if (e_issue && dec_wr_rd && dec_rd != 0) m_pend[dec_rd] = 1;
      old = m_infl;
      m_infl = old + int'(e_issue) - int'(wb_retire && old > 0);
      if (exec_redirect) begin m_left = FC; m_stalled = 0; end
      else if (m_left > 0) begin m_left--; m_stalled = 0; end
      else m_stalled = e_stl;
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    set_in(1, 1, 2, 3, 1, 1, 1, 0, 1, 1, 3, 1);
    #12;
    vecs++; if (gotv() !== 42'd0) begin errs++; $display("FAIL reset_hold got=%h exp=0", gotv()); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1; m_reset();
    sample();
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL reset_release got=%h exp=%h", gotv(), expv()); end
    tick();
  endtask
  task automatic test_bypass();
    set_in(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    sample();
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL byp_issue got=%h exp=%h", gotv(), expv()); end
    tick();
    set_in(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    sample();
    vecs++; if (ftch_stall !== 1'b1) begin errs++; $display("FAIL byp_stall got=%b exp=1", ftch_stall); end
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL byp_stall_all got=%h exp=%h", gotv(), expv()); end
    tick();
    vecs++; if (ctrl_state !== 2'd1) begin errs++; $display("FAIL byp_state got=%0d exp=1", ctrl_state); end
    set_in(1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 5, 1);
    sample();
    vecs++; if (dec_issue !== 1'b1) begin errs++; $display("FAIL byp_same_cycle got=%b exp=1", dec_issue); end
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL byp_wb_all got=%h exp=%h", gotv(), expv()); end
    tick();
    vecs++; if (ctrl_pending[5] !== 1'b0) begin errs++; $display("FAIL byp_pend5 got=%b exp=0", ctrl_pending[5]); end
  endtask
  task automatic test_x0();
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    sample();
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL x0_issue got=%h exp=%h", gotv(), expv()); end
    tick();
    vecs++; if (ctrl_pending !== 32'd0) begin errs++; $display("FAIL x0_pend got=%h exp=0", ctrl_pending); end
    set_in(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    sample();
    vecs++; if ({ftch_stall, dec_issue} !== 2'b01) begin errs++; $display("FAIL x0_read got=%b exp=01", {ftch_stall, dec_issue}); end
    tick();
  endtask
  task automatic test_redirect();
    int n = 0;
    set_in(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 1);
    sample();
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL rd_setup got=%h exp=%h", gotv(), expv()); end
    tick();
    set_in(1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    sample();
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL rd_stall got=%h exp=%h", gotv(), expv()); end
    tick();
    exec_redirect = 1;
    sample();
    vecs++; if ({dec_flush, dec_issue, ftch_stall} !== 3'b100) begin errs++; $display("FAIL rd_redirect got=%b exp=100", {dec_flush, dec_issue, ftch_stall}); end
    tick();
    exec_redirect = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL rd_flush%0d got=%h exp=%h", i, gotv(), expv()); end
      if (!dec_flush) break;
      n++;
      tick();
    end
    vecs++; if (n != FC) begin errs++; $display("FAIL rd_flush_len got=%0d exp=%0d", n, FC); end
    vecs++; if (ctrl_state !== 2'd0 || ctrl_pending[9] !== 1'b1) begin errs++; $display("FAIL rd_after state=%0d pend9=%b exp=0,1", ctrl_state, ctrl_pending[9]); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    sample(); tick();
  endtask
  task automatic test_full();
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      sample();
      vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL full_drain%0d got=%h exp=%h", i, gotv(), expv()); end
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 0, 0, 5'(i), 0, 0, 1, 0, 0, 0, 0, 0);
      sample();
      vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL full_issue%0d got=%h exp=%h", i, gotv(), expv()); end
      tick();
    end
    vecs++; if (ctrl_inflight !== 4'd4) begin errs++; $display("FAIL full_count got=%0d exp=4", ctrl_inflight); end
    set_in(1, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0, 0);
    sample();
    vecs++; if ({ftch_stall, dec_issue} !== 2'b10) begin errs++; $display("FAIL full_stall got=%b exp=10", {ftch_stall, dec_issue}); end
    tick();
    wb_retire = 1;
    sample();
    vecs++; if (dec_issue !== 1'b1) begin errs++; $display("FAIL full_retire_issue got=%b exp=1", dec_issue); end
    tick();
    vecs++; if (ctrl_inflight !== 4'd4) begin errs++; $display("FAIL full_hold got=%0d exp=4", ctrl_inflight); end
  endtask
  task automatic test_same_cycle();
    set_in(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1);
    sample();
    vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL sc_setup got=%h exp=%h", gotv(), expv()); end
    tick();
    set_in(1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 7, 1);
    sample();
    vecs++; if (dec_issue !== 1'b1) begin errs++; $display("FAIL sc_issue got=%b exp=1", dec_issue); end
    tick();
    vecs++; if (ctrl_pending[7] !== 1'b1) begin errs++; $display("FAIL sc_pend7 got=%b exp=1", ctrl_pending[7]); end
  endtask
  task automatic test_reset_mid();
    rst_n = 0; #2;
    @(negedge clk); rst_n = 1; m_reset();
    set_in(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0); sample(); tick();
    set_in(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0); sample(); tick();
    set_in(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); sample(); tick();
    vecs++; if ({ctrl_state, ctrl_pending} !== {2'd1, 32'h0000_00A0}) begin errs++; $display("FAIL rm_pre got=%h exp=1_000000a0", {ctrl_state, ctrl_pending}); end
    #2 rst_n = 0;
    #1;
    vecs++; if (gotv() !== 42'd0) begin errs++; $display("FAIL rm_async got=%h exp=0", gotv()); end
    m_reset();
    @(negedge clk); rst_n = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    vecs++; if (gotv() !== expv() || ctrl_pending !== 32'd0) begin errs++; $display("FAIL rm_release got=%h exp=%h", gotv(), expv()); end
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      sample();
      vecs++; if (gotv() !== expv()) begin errs++; $display("FAIL rand%0d got=%h exp=%h", i, gotv(), expv()); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_redirect();
    test_full();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
